// File: rtl/seg7_scan_mux.sv
// seg7_scan_mux: time-multiplexed N-digit BCD seven-segment driver.
// One shared decode path serves every digit while a scan counter walks the
// anodes. Digit values, decimal points and blink enables are captured once per
// frame into shadow registers, so the display never tears mid-frame. Each
// digit slot begins with one dark cycle to hide ghosting while the anodes
// switch. Optional leading-zero suppression is enabled by defining the macro
// SEG7_LZ_BLANK_EN; without it every digit, including leading zeros, is shown.
module seg7_scan_mux #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLINK_FRAMES = 50,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_start
);

    localparam int IDX_W   = $clog2(NUM_DIGITS);
    localparam int SCAN_W  = $clog2(SCAN_DIV);
    localparam int BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_FRAMES - 1);
    localparam logic               INV        = (ACTIVE_LOW != 0);

    logic [SCAN_W-1:0]       scan_cnt;
    logic [IDX_W-1:0]        idx;
    logic [BLINK_W-1:0]      blink_cnt;
    logic                    phase;

    logic [4*NUM_DIGITS-1:0] shadow_digits;
    logic [NUM_DIGITS-1:0]   shadow_dp;
    logic [NUM_DIGITS-1:0]   shadow_blink;

    logic                    slot_end;
    logic                    frame_end;

    logic [3:0]              cur_digit;
    logic                    cur_dp;
    logic                    cur_blink;
    logic                    cur_lz;

    logic [6:0]              seg_next;
    logic                    dp_next;
    logic [NUM_DIGITS-1:0]   an_next;

    assign slot_end  = (scan_cnt == SCAN_LAST);
    assign frame_end = slot_end && (idx == IDX_LAST);

    // Shared BCD to segment decode, A..G high-true; non-BCD codes stay dark
    function automatic logic [6:0] decode_bcd(input logic [3:0] value);
        logic [6:0] pattern;
        case (value)
            4'd0:    pattern = 7'h7E;
            4'd1:    pattern = 7'h30;
            4'd2:    pattern = 7'h6D;
            4'd3:    pattern = 7'h79;
            4'd4:    pattern = 7'h33;
            4'd5:    pattern = 7'h5B;
            4'd6:    pattern = 7'h5F;
            4'd7:    pattern = 7'h70;
            4'd8:    pattern = 7'h7F;
            4'd9:    pattern = 7'h7B;
            default: pattern = 7'h00;
        endcase
        return pattern;
    endfunction

    // Slot timer and digit index: idx advances once per slot and wraps per frame
    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt <= '0;
            idx      <= '0;
        end else if (slot_end) begin
            scan_cnt <= '0;
            idx      <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
        end else begin
            scan_cnt <= scan_cnt + SCAN_W'(1);
        end
    end

    // Shadow copy of the inputs: tracks them during reset, then refreshes only at frame end
    always_ff @(posedge clk) begin
        if (rst || frame_end) begin
            shadow_digits <= digits;
            shadow_dp     <= dp_in;
            shadow_blink  <= blink_mask;
        end
    end

    // Blink timer: counts captured frames and flips the blank phase every BLINK_FRAMES frames
    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            phase     <= 1'b0;
        end else if (frame_end) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt <= '0;
                phase     <= ~phase;
            end else begin
                blink_cnt <= blink_cnt + BLINK_W'(1);
            end
        end
    end

    // One-cycle marker in the cycle after a new frame has been captured
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_end;
        end
    end

    // Pick the shadow fields belonging to the digit currently being scanned
    always_comb begin
        cur_digit = 4'd0;
        cur_dp    = 1'b0;
        cur_blink = 1'b0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_digit = shadow_digits[4*k +: 4];
                cur_dp    = shadow_dp[k];
                cur_blink = shadow_blink[k];
            end
        end
    end

`ifdef SEG7_LZ_BLANK_EN
    // Leading-zero test: a non-units digit goes blank when it and every more significant digit are zero
    always_comb begin
        cur_lz = 1'b0;
        for (int k = 1; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                cur_lz = 1'b1;
                for (int j = k; j < NUM_DIGITS; j++) begin
                    if (shadow_digits[4*j +: 4] != 4'd0) begin
                        cur_lz = 1'b0;
                    end
                end
            end
        end
    end
`else
    assign cur_lz = 1'b0;
`endif

    // Logical next outputs: dead cycle at slot start, then blink blank, leading-zero blank, decode
    always_comb begin
        an_next  = '0;
        seg_next = 7'h00;
        dp_next  = 1'b0;
        if (!slot_end && !(phase && cur_blink)) begin
            an_next = NUM_DIGITS'(1) << idx;
            if (!cur_lz) begin
                seg_next = decode_bcd(cur_digit);
                dp_next  = cur_dp;
            end
        end
    end

    // Pin registers: dark during reset, polarity applied here so the pins never glitch
    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= {7{INV}};
            dp  <= INV;
            an  <= {NUM_DIGITS{INV}};
        end else begin
            seg <= seg_next ^ {7{INV}};
            dp  <= dp_next ^ INV;
            an  <= an_next ^ {NUM_DIGITS{INV}};
        end
    end

endmodule

// File: tb/tb_seg7_scan_mux.sv
// tb_seg7_scan_mux: self-checking bench for seg7_scan_mux with 4 digits,
// 4 clocks per slot, 2 frames per blink phase and high-true pins. A
// behavioural model derives the expected pins from the number of clocks since
// reset and checks them every cycle; directed literal checks pin the model.
// Expectations follow SEG7_LZ_BLANK_EN when it is defined.
module tb_seg7_scan_mux;

    localparam int N  = 4;
    localparam int S  = 4;
    localparam int BF = 2;
    localparam int AL = 0;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] digits = 16'h1234;
    logic [3:0]  dp_in = 4'b0000;
    logic [3:0]  blink_mask = 4'b0000;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_start;

    int num_checks = 0;
    int num_fail   = 0;

    seg7_scan_mux #(
        .NUM_DIGITS(N),
        .SCAN_DIV(S),
        .BLINK_FRAMES(BF),
        .ACTIVE_LOW(AL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .digits(digits),
        .dp_in(dp_in),
        .blink_mask(blink_mask),
        .seg(seg),
        .dp(dp),
        .an(an),
        .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        case (v)
            4'd0: return 7'h7E;
            4'd1: return 7'h30;
            4'd2: return 7'h6D;
            4'd3: return 7'h79;
            4'd4: return 7'h33;
            4'd5: return 7'h5B;
            4'd6: return 7'h5F;
            4'd7: return 7'h70;
            4'd8: return 7'h7F;
            4'd9: return 7'h7B;
            default: return 7'h00;
        endcase
    endfunction

    function automatic logic [11:0] pins(input logic [3:0] a, input logic [6:0] s, input logic d);
        return (AL != 0) ? ~{a, s, d} : {a, s, d};
    endfunction

    // Reference model: position since reset selects slot, dead cycle, frame and blink phase
    int          p = 0;
    int          m_slot, m_within, m_frame;
    logic [15:0] m_digits;
    logic [3:0]  m_dp, m_mask;
    logic        m_lz;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_dp, e_fs;
    bit          model_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_digits    = digits;
            m_dp        = dp_in;
            m_mask      = blink_mask;
            p           = 0;
            e_an        = 4'b0000;
            e_seg       = 7'h00;
            e_dp        = 1'b0;
            e_fs        = 1'b0;
            model_valid = 1'b1;
        end else if (model_valid) begin
            m_slot   = (p / S) % N;
            m_within = p % S;
            m_frame  = p / (N * S);
            e_an     = 4'b0000;
            e_seg    = 7'h00;
            e_dp     = 1'b0;
            e_fs     = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
            m_lz = (m_slot >= 1) && ((m_digits >> (4 * m_slot)) == 16'd0);
`else
            m_lz = 1'b0;
`endif
            if (m_within != S - 1) begin
                if (!(((m_frame / BF) % 2 == 1) && m_mask[m_slot])) begin
                    e_an = 4'(1 << m_slot);
                    if (!m_lz) begin
                        e_seg = ref_seg(m_digits[m_slot*4 +: 4]);
                        e_dp  = m_dp[m_slot];
                    end
                end
            end
            if (p % (N * S) == N * S - 1) begin
                m_digits = digits;
                m_dp     = dp_in;
                m_mask   = blink_mask;
                e_fs     = 1'b1;
            end
            p = p + 1;
        end
    end

    // Per-cycle comparison of all DUT outputs against the model
    logic [11:0] exp_pins;
    always @(negedge clk) begin
        if (model_valid) begin
            exp_pins = pins(e_an, e_seg, e_dp);
            num_checks++;
            if ({an, seg, dp, frame_start} !== {exp_pins, e_fs}) begin
                num_fail++;
                $display("[TB] FAIL model_cmp t=%0t: got an=%b seg=%h dp=%b fs=%b, required an=%b seg=%h dp=%b fs=%b",
                         $time, an, seg, dp, frame_start, exp_pins[11:8], exp_pins[7:1], exp_pins[0], e_fs);
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p_dp, input logic [3:0] m);
        digits     = d;
        dp_in      = p_dp;
        blink_mask = m;
    endtask

    task automatic checkOutput(input string name, input logic [3:0] exp_an, input logic [6:0] exp_seg, input logic exp_dp);
        logic [11:0] want;
        want = pins(exp_an, exp_seg, exp_dp);
        num_checks++;
        if ({an, seg, dp} !== want) begin
            num_fail++;
            $display("[TB] FAIL %s: got an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
                     name, an, seg, dp, want[11:8], want[7:1], want[0]);
        end
    endtask

    task automatic checkFs(input string name, input logic exp_fs);
        num_checks++;
        if (frame_start !== exp_fs) begin
            num_fail++;
            $display("[TB] FAIL %s: got frame_start=%b, required %b", name, frame_start, exp_fs);
        end
    endtask

    task automatic waitFrameStart(input string name);
        int k;
        k = 0;
        while (frame_start !== 1'b1 && k < 64) begin
            step(1);
            k++;
        end
        num_checks++;
        if (frame_start !== 1'b1) begin
            num_fail++;
            $display("[TB] FAIL %s: got no frame_start within 64 cycles, required a pulse", name);
        end
    endtask

    task automatic checkResetFrame(input string name, input logic [15:0] d, input logic [3:0] p_dp,
                                   input logic [27:0] exp_segs, input logic [3:0] exp_dps);
        rst = 1'b1;
        applyStimulus(d, p_dp, 4'b0000);
        step(2);
        rst = 1'b0;
        checkOutput({name, "_dark"}, 4'b0000, 7'h00, 1'b0);
        step(1);
        for (int j = 0; j < 4; j++) begin
            checkOutput($sformatf("%s_d%0d", name, j), 4'(1 << j), exp_segs[j*7 +: 7], exp_dps[j]);
            if (j < 3) step(4);
        end
    endtask

    int blink_exp[5] = '{3, 3, 0, 0, 3};

    // Directed scenarios followed by randomized traffic
    initial begin
        int cnt0, cnt2;
        logic [3:0] an_l;
        logic [15:0] rd;

        // Reset with 1234, then slot timing and dead cycles
        step(3);
        rst = 1'b0;
        checkOutput("t1_c1", 4'b0000, 7'h00, 1'b0);
        for (int i = 2; i <= 8; i++) begin
            step(1);
            if (i == 5)     checkOutput($sformatf("t1_c%0d", i), 4'b0000, 7'h00, 1'b0);
            else if (i < 5) checkOutput($sformatf("t1_c%0d", i), 4'b0001, 7'h33, 1'b0);
            else            checkOutput($sformatf("t1_c%0d", i), 4'b0010, 7'h79, 1'b0);
        end

        // Frame coherence: new digits mid-frame only appear after capture
        applyStimulus(16'h5678, 4'b0000, 4'b0000);
        step(2);
        checkOutput("t2_d2_old", 4'b0100, 7'h6D, 1'b0);
        step(4);
        checkOutput("t2_d3_old", 4'b1000, 7'h30, 1'b0);
        step(3);
        checkFs("t2_fs_pulse", 1'b1);
        checkOutput("t2_fs_dark", 4'b0000, 7'h00, 1'b0);
        step(1);
        checkFs("t2_fs_low", 1'b0);
        checkOutput("t2_d0_new", 4'b0001, 7'h7F, 1'b0);
        step(4);
        checkOutput("t2_d1_new", 4'b0010, 7'h70, 1'b0);

        // Invalid BCD code keeps anode and dp but blanks segments
        applyStimulus(16'h00A9, 4'b0010, 4'b0000);
        waitFrameStart("t3_fs");
        step(1);
        checkOutput("t3_d0", 4'b0001, 7'h7B, 1'b0);
        step(4);
        checkOutput("t3_d1_invalid", 4'b0010, 7'h00, 1'b1);

        // Blink: digit 2 visible two frames, blank two frames
        rst = 1'b1;
        applyStimulus(16'h4321, 4'b0000, 4'b0100);
        step(2);
        rst = 1'b0;
        for (int f = 0; f < 5; f++) begin
            cnt0 = 0;
            cnt2 = 0;
            for (int c = 0; c < 16; c++) begin
                step(1);
                an_l = (AL != 0) ? ~an : an;
                if (an_l[0]) cnt0++;
                if (an_l[2]) cnt2++;
            end
            num_checks++;
            if (cnt2 != blink_exp[f]) begin
                num_fail++;
                $display("[TB] FAIL t4_blink_f%0d: got %0d cycles of an[2], required %0d", f, cnt2, blink_exp[f]);
            end
            num_checks++;
            if (cnt0 != 3) begin
                num_fail++;
                $display("[TB] FAIL t4_steady_f%0d: got %0d cycles of an[0], required 3", f, cnt0);
            end
        end

        // Leading zeros
`ifdef SEG7_LZ_BLANK_EN
        checkResetFrame("t5_0050", 16'h0050, 4'b0000, {7'h00, 7'h00, 7'h5B, 7'h7E}, 4'b0000);
        checkResetFrame("t5_0000", 16'h0000, 4'b1111, {7'h00, 7'h00, 7'h00, 7'h7E}, 4'b0001);
`else
        checkResetFrame("t5_0050", 16'h0050, 4'b0000, {7'h7E, 7'h7E, 7'h5B, 7'h7E}, 4'b0000);
        checkResetFrame("t5_0000", 16'h0000, 4'b1111, {7'h7E, 7'h7E, 7'h7E, 7'h7E}, 4'b1111);
`endif

        // Reset mid-scan at idx 2, scan_cnt 2
        rst = 1'b1;
        applyStimulus(16'h1111, 4'b0000, 4'b0000);
        step(2);
        rst = 1'b0;
        step(10);
        rst = 1'b1;
        applyStimulus(16'h9876, 4'b0000, 4'b0000);
        step(1);
        checkOutput("t6_dark", 4'b0000, 7'h00, 1'b0);
        checkFs("t6_fs", 1'b0);
        rst = 1'b0;
        step(1);
        checkOutput("t6_d0", 4'b0001, 7'h5F, 1'b0);
        step(4);
        checkOutput("t6_d1", 4'b0010, 7'h70, 1'b0);

        // Randomized traffic with occasional resets
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 299) == 0);
            if ($urandom_range(0, 7) == 0) begin
                for (int k = 0; k < 4; k++) begin
                    rd[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 11));
                end
                applyStimulus(rd, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            end
            step(1);
        end
        rst = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fail);
        $finish;
    end

    // Safety net so the run always terminates
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion by %0t, required finish", $time);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/seg7_scan_mux.md
Name: seg7_scan_mux

Overview:
- Parametrised, time-multiplexed N-digit BCD seven-segment display driver.
- Replaces one-decoder-per-digit wiring: a single decode path is shared across digits, with a scan counter cycling digit anodes.
- Adds frame-coherent digit capture, anti-ghost dead time, per-digit blink and decimal points.
- Sits between alarm-clock time/alarm registers and the board's shared segment/anode pins.

Parameters:
NUM_DIGITS, 4, digits scanned; legal range 2..8; digit NUM_DIGITS-1 is most significant.
SCAN_DIV, 1000, clocks per digit slot; legal minimum 2.
BLINK_FRAMES, 50, full scan frames per blink phase; legal minimum 1.
ACTIVE_LOW, 1, 1 = seg/dp/an driven low-true; 0 = high-true.

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
digits  in  4*NUM_DIGITS  BCD digit k at bits [4k+3:4k]
dp_in  in  NUM_DIGITS  decimal point request per digit
blink_mask  in  NUM_DIGITS  1 = digit blinks
seg  out  7  seg[6]=A, seg[5]=B ... seg[0]=G
dp  out  1  decimal point of active digit
an  out  NUM_DIGITS  one-hot digit enable
frame_start  out  1  one-cycle pulse when a new frame is captured

Behaviour:
- Polarity: all statements below use logical (high-true) values. With ACTIVE_LOW=1, seg, dp and an are inverted at the output registers; frame_start is never inverted.
- Reset: one clock; reset is synchronous and active-high.
  - scan_cnt=0, idx=0, blink_cnt=0, phase=0.
  - seg=0, dp=0, an=0 (all dark), frame_start=0.
  - While rst=1, the shadow registers load digits/dp_in/blink_mask every cycle, so the first frame shows values present at the last reset cycle.
  - A reset mid-scan aborts the slot; the next cycle is dark.
- Scan counter: scan_cnt counts 0..SCAN_DIV-1.
  - At SCAN_DIV-1, scan_cnt wraps to 0 and idx advances; idx wraps NUM_DIGITS-1 -> 0.
  - idx width is $clog2(NUM_DIGITS).
- Frame capture: on the cycle scan_cnt==SCAN_DIV-1 and idx==NUM_DIGITS-1:
  - shadow <= {digits, dp_in, blink_mask}.
  - frame_start is registered high for the next cycle only.
  - Input changes at other times never affect the frame in progress.
- Blink:
  - At each frame capture, blink_cnt increments.
  - At BLINK_FRAMES-1, blink_cnt wraps to 0 and phase toggles.
  - phase=1 blanks every digit whose shadow blink_mask bit is 1: an bit 0, seg 0, dp 0.
- Output registers, updated every cycle:
  - If rst, or scan_cnt==SCAN_DIV-1: an=0, seg=0, dp=0. This gives a one-cycle dead time at each slot start.
  - Otherwise: an=onehot(idx), seg=decode(shadow digit idx), dp=shadow dp idx, subject to blanking.
  - A digit is visible for SCAN_DIV-1 cycles per slot.
  - Frame period = NUM_DIGITS*SCAN_DIV cycles.
- Decode (A..G, high-true): 0=7E, 1=30, 2=6D, 3=79, 4=33, 5=5B, 6=5F, 7=70, 8=7F, 9=7B. Codes 10..15 give seg=00; an and dp stay driven.
- Blanking precedence: blink blank > leading-zero blank (optional) > decode.

Optional Feature:
Macro SEG7_LZ_BLANK_EN.
- Defined: digit k (k>=1) has seg=00 and dp=0 when shadow digits k..NUM_DIGITS-1 are all 0. an still asserts. Digit 0 is never suppressed, so value 0 shows a single "0".
- Undefined: no suppression; all zeros are displayed.

Test Plan:
(All scenarios use NUM_DIGITS=4, SCAN_DIV=4, BLINK_FRAMES=2, ACTIVE_LOW=0.)
1. Reset/dead time: rst=1 for 3 cycles with digits=16'h1234, then release.
   - Cycle 1 after release: an=0000.
   - Cycles 2-4: an=0001, seg=7'h33.
   - Cycle 5: dark.
   - Cycles 6-8: an=0010, seg=7'h79.
2. Frame coherence: change digits to 16'h5678 mid-frame (idx=1).
   - Digits 2 and 3 still show 2 (6D) and 1 (30).
   - frame_start pulses.
   - Next frame shows 8, 7, 6, 5.
3. Invalid code: digits=16'h00A9.
   - Digit 0 seg=7B; digit 1 an=0010 with seg=00; dp follows dp_in.
4. Blink: blink_mask=4'b0100.
   - Frames 0-1: digit 2 visible.
   - Frames 2-3: an bit2 never asserts; other digits unaffected.
   - Period repeats every 4 frames.
5. Leading zeros (macro defined): digits=16'h0050.
   - Digits 3 and 2 give seg=00; digit 1 seg=5B; digit 0 seg=7E.
   - digits=0000 shows only digit 0 = 7E.
   - Macro undefined: all four digits show 7E.
6. Reset mid-scan: assert rst at scan_cnt=2, idx=2.
   - Next cycle all outputs dark.
   - After release, scan restarts at idx=0 with the new shadow.
